// File: rtl/mips_pkg.sv
// Shared MIPS decode constants, control-field encodings and the multi-cycle state set.
package mips_pkg;

  // Primary opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_LH    = 6'b100001;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BGEZ  = 6'b000001;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  // R-type function codes (IR[5:0])
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_SRAV = 6'b000111;
  localparam logic [5:0] FN_JR   = 6'b001000;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'd0,
    ALU_SUB  = 3'd1,
    ALU_OR   = 3'd2,
    ALU_LUI  = 3'd3,
    ALU_SRAV = 3'd4
  } alu_op_e;

  typedef enum logic [1:0] {
    PC_PLUS4  = 2'b00,
    PC_BRANCH = 2'b01,
    PC_JUMP   = 2'b10,
    PC_RS     = 2'b11
  } pc_src_e;

  typedef enum logic [1:0] {
    SRCB_RT      = 2'b00,
    SRCB_FOUR    = 2'b01,
    SRCB_IMM     = 2'b10,
    SRCB_IMM_SH2 = 2'b11
  } srcb_e;

  typedef enum logic [1:0] {
    DST_RT = 2'b00,
    DST_RD = 2'b01,
    DST_RA = 2'b10
  } regdst_e;

  typedef enum logic [1:0] {
    WB_ALUOUT   = 2'b00,
    WB_MDR_WORD = 2'b01,
    WB_PC       = 2'b10,
    WB_MDR_HALF = 2'b11
  } memtoreg_e;

  typedef enum logic [1:0] {
    SIGN_ZERO   = 2'b00,
    SIGN_SIGNED = 2'b01
  } sign_e;

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_ADDR, S_MEMRD,
    S_MEMWR, S_WB_ALU, S_WB_MEM, S_BRANCH, S_JAL, S_JR, S_ERR
  } state_e;

  typedef enum logic [3:0] {
    IC_ILLEGAL, IC_RTYPE, IC_ITYPE, IC_LW, IC_LH, IC_SW,
    IC_BEQ, IC_BGEZ, IC_JAL, IC_JR
  } iclass_e;

endpackage

// File: rtl/multicycle_controller_if.sv
// IR fields, datapath status, memory handshake and control/status outputs of the controller.
interface multicycle_controller_if #(
  parameter int ALUOP_W = 3,
  parameter int CNT_W   = 32
);
  logic [5:0]         Option;
  logic [5:0]         Function;
  logic               alu_zero;
  logic               rs_neg;
  logic               mem_ready;
  logic               MemRead;
  logic               MemWrite;
  logic               IorD;
  logic               IRWrite;
  logic               PCWrite;
  logic [1:0]         PCSource;
  logic               ALUSrcA;
  logic [1:0]         ALUSrcB;
  logic [ALUOP_W-1:0] ALUOp;
  logic [1:0]         Sign;
  logic [1:0]         RegDst;
  logic [1:0]         MemtoReg;
  logic               RegWrite;
  logic               instr_done;
  logic               illegal;
  logic               timeout_err;
  logic [CNT_W-1:0]   retired;

  modport master (
    input  Option, Function, alu_zero, rs_neg, mem_ready,
    output MemRead, MemWrite, IorD, IRWrite, PCWrite, PCSource, ALUSrcA, ALUSrcB,
           ALUOp, Sign, RegDst, MemtoReg, RegWrite, instr_done, illegal, timeout_err, retired
  );

  modport slave (
    output Option, Function, alu_zero, rs_neg, mem_ready,
    input  MemRead, MemWrite, IorD, IRWrite, PCWrite, PCSource, ALUSrcA, ALUSrcB,
           ALUOp, Sign, RegDst, MemtoReg, RegWrite, instr_done, illegal, timeout_err, retired
  );
endinterface

// File: rtl/mc_decode.sv
// Combinational IR decode: instruction class and ALU function for the execute states.
module mc_decode
  import mips_pkg::*;
(
  input  logic [5:0] option,
  input  logic [5:0] funct,
  output iclass_e    iclass,
  output alu_op_e    alu_op
);

  // Classify Option/Function; anything unlisted falls through as illegal.
  always_comb begin
    iclass = IC_ILLEGAL;
    alu_op = ALU_ADD;
    case (option)
      OP_RTYPE: begin
        case (funct)
          FN_ADDU: begin iclass = IC_RTYPE; alu_op = ALU_ADD;  end
          FN_SUBU: begin iclass = IC_RTYPE; alu_op = ALU_SUB;  end
          FN_SRAV: begin iclass = IC_RTYPE; alu_op = ALU_SRAV; end
          FN_JR:   iclass = IC_JR;
          default: iclass = IC_ILLEGAL;
        endcase
      end
      OP_ORI:  begin iclass = IC_ITYPE; alu_op = ALU_OR;  end
      OP_LUI:  begin iclass = IC_ITYPE; alu_op = ALU_LUI; end
      OP_LW:   iclass = IC_LW;
      OP_LH:   iclass = IC_LH;
      OP_SW:   iclass = IC_SW;
      OP_BEQ:  begin iclass = IC_BEQ;  alu_op = ALU_SUB; end
      OP_BGEZ: begin iclass = IC_BGEZ; alu_op = ALU_SUB; end
      OP_JAL:  iclass = IC_JAL;
      default: iclass = IC_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle MIPS controller: Moore FSM over fetch/decode/execute/memory/write-back
// with a variable-latency memory handshake, wait timeout and retire accounting.
module multicycle_controller
  import mips_pkg::*;
#(
  parameter int ALUOP_W = 3,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input logic                      clk,
  input logic                      reset_n,
  multicycle_controller_if.master  bus
);

  localparam int WAIT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  state_e            state_reg, state_next;
  logic [WAIT_W-1:0] wait_cnt_reg;
  logic              illegal_reg, timeout_reg;
  logic [CNT_W-1:0]  retired_reg;

  iclass_e   iclass;
  alu_op_e   dec_alu_op;
  logic      req_state, waiting, timeout_hit;

  logic      mem_read, mem_write, iord, ir_write, pc_write, alu_src_a, reg_write, instr_done;
  pc_src_e   pc_source;
  srcb_e     alu_src_b;
  alu_op_e   alu_op;
  sign_e     sign;
  regdst_e   reg_dst;
  memtoreg_e mem_to_reg;

  mc_decode u_decode (
    .option (bus.Option),
    .funct  (bus.Function),
    .iclass (iclass),
    .alu_op (dec_alu_op)
  );

  // The IR is stable from DECODE on, so the decoded class is reused in every later state.
  assign req_state   = (state_reg == S_FETCH) || (state_reg == S_MEMRD) || (state_reg == S_MEMWR);
  assign waiting     = req_state && !bus.mem_ready;
  assign timeout_hit = (TIMEOUT > 0) && waiting && (wait_cnt_reg == WAIT_W'(TIMEOUT - 1));

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_reg <= S_IDLE;
    else          state_reg <= state_next;
  end

  // Next-state selection; a memory timeout overrides every other transition.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:   state_next = S_FETCH;
      S_FETCH:  if (bus.mem_ready) state_next = S_DECODE;
      S_DECODE: begin
        case (iclass)
          IC_RTYPE:             state_next = S_EXEC_R;
          IC_ITYPE:             state_next = S_EXEC_I;
          IC_LW, IC_LH, IC_SW:  state_next = S_ADDR;
          IC_BEQ, IC_BGEZ:      state_next = S_BRANCH;
          IC_JAL:               state_next = S_JAL;
          IC_JR:                state_next = S_JR;
          default:              state_next = S_FETCH;
        endcase
      end
      S_EXEC_R, S_EXEC_I: state_next = S_WB_ALU;
      S_ADDR:   state_next = (iclass == IC_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  if (bus.mem_ready) state_next = S_WB_MEM;
      S_MEMWR:  if (bus.mem_ready) state_next = S_FETCH;
      S_WB_ALU, S_WB_MEM, S_BRANCH, S_JAL, S_JR: state_next = S_FETCH;
      S_ERR:    state_next = S_ERR;
      default:  state_next = S_IDLE;
    endcase
    if (timeout_hit) state_next = S_ERR;
  end

  // Control outputs per state; only FETCH/MEMWR/BRANCH also look at live inputs.
  always_comb begin
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_source  = PC_PLUS4;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_RT;
    alu_op     = ALU_ADD;
    sign       = SIGN_ZERO;
    reg_dst    = DST_RT;
    mem_to_reg = WB_ALUOUT;
    reg_write  = 1'b0;
    instr_done = 1'b0;
    case (state_reg)
      S_FETCH: begin
        mem_read = 1'b1;
        if (bus.mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
        end
      end
      S_DECODE: alu_src_b = SRCB_IMM_SH2;
      S_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_op    = dec_alu_op;
      end
      S_EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_op    = dec_alu_op;
      end
      S_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        sign      = SIGN_SIGNED;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      S_MEMWR: begin
        mem_write  = 1'b1;
        iord       = 1'b1;
        instr_done = bus.mem_ready;
      end
      S_WB_ALU: begin
        reg_write  = 1'b1;
        reg_dst    = (iclass == IC_RTYPE) ? DST_RD : DST_RT;
        instr_done = 1'b1;
      end
      S_WB_MEM: begin
        reg_write  = 1'b1;
        mem_to_reg = (iclass == IC_LH) ? WB_MDR_HALF : WB_MDR_WORD;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a  = 1'b1;
        alu_op     = ALU_SUB;
        pc_source  = PC_BRANCH;
        pc_write   = ((iclass == IC_BEQ) && bus.alu_zero) || ((iclass == IC_BGEZ) && !bus.rs_neg);
        instr_done = 1'b1;
      end
      S_JAL: begin
        reg_write  = 1'b1;
        reg_dst    = DST_RA;
        mem_to_reg = WB_PC;
        pc_write   = 1'b1;
        pc_source  = PC_JUMP;
        instr_done = 1'b1;
      end
      S_JR: begin
        pc_write   = 1'b1;
        pc_source  = PC_RS;
        instr_done = 1'b1;
      end
      default: ;
    endcase
  end

  // Wait counter, sticky error flags and the retired-instruction count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt_reg <= '0;
      illegal_reg  <= 1'b0;
      timeout_reg  <= 1'b0;
      retired_reg  <= '0;
    end else begin
      if (waiting && (state_next == state_reg)) wait_cnt_reg <= wait_cnt_reg + WAIT_W'(1);
      else                                      wait_cnt_reg <= '0;
      if ((state_reg == S_DECODE) && (iclass == IC_ILLEGAL)) illegal_reg <= 1'b1;
      if (timeout_hit) timeout_reg <= 1'b1;
      if (instr_done)  retired_reg <= retired_reg + CNT_W'(1);
    end
  end

  assign bus.MemRead     = mem_read;
  assign bus.MemWrite    = mem_write;
  assign bus.IorD        = iord;
  assign bus.IRWrite     = ir_write;
  assign bus.PCWrite     = pc_write;
  assign bus.PCSource    = pc_source;
  assign bus.ALUSrcA     = alu_src_a;
  assign bus.ALUSrcB     = alu_src_b;
  assign bus.ALUOp       = ALUOP_W'(alu_op);
  assign bus.Sign        = sign;
  assign bus.RegDst      = reg_dst;
  assign bus.MemtoReg    = mem_to_reg;
  assign bus.RegWrite    = reg_write;
  assign bus.instr_done  = instr_done;
  assign bus.illegal     = illegal_reg;
  assign bus.timeout_err = timeout_reg;
  assign bus.retired     = retired_reg;

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized bench: each instruction is expanded into its expected per-cycle control
// words from the instruction's phase list, then compared cycle by cycle.
module tb_multicycle_controller;

  localparam int TIMEOUT = 16;

  // ALU function codes used by this controller
  localparam logic [2:0] A_ADD = 3'd0, A_SUB = 3'd1, A_OR = 3'd2, A_LUI = 3'd3, A_SRAV = 3'd4;

  typedef struct packed {
    logic       mem_read, mem_write, iord, ir_write, pc_write;
    logic [1:0] pc_source;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] sign, reg_dst, mem_to_reg;
    logic       reg_write, instr_done;
  } ctl_t;

  typedef enum int {K_ADDU, K_SUBU, K_SRAV, K_ORI, K_LUI, K_LW, K_LH, K_SW,
                    K_BEQ, K_BGEZ, K_JAL, K_JR, K_ILL} kind_e;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  multicycle_controller_if #(.ALUOP_W(3), .CNT_W(32)) bus();

  multicycle_controller #(.ALUOP_W(3), .TIMEOUT(TIMEOUT), .CNT_W(32)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  ctl_t obs_ctl;
  assign obs_ctl = {bus.MemRead, bus.MemWrite, bus.IorD, bus.IRWrite, bus.PCWrite, bus.PCSource,
                    bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp, bus.Sign, bus.RegDst, bus.MemtoReg,
                    bus.RegWrite, bus.instr_done};

  int   n_checks = 0;
  int   n_errors = 0;
  int   exp_retired = 0;
  logic exp_illegal = 1'b0;
  logic exp_timeout = 1'b0;

  logic [5:0] cur_opt = 6'd0;
  logic [5:0] cur_fn  = 6'd0;
  logic       cur_az  = 1'b0;
  logic       cur_rn  = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic rbit();
    return 1'($urandom);
  endfunction

  task automatic check_cycle(input ctl_t e, input string tag);
    check({tag, ".ctl"}, 32'(obs_ctl), 32'(e));
    check({tag, ".retired"}, bus.retired, 32'(exp_retired));
    check({tag, ".illegal"}, 32'(bus.illegal), 32'(exp_illegal));
    check({tag, ".timeout_err"}, 32'(bus.timeout_err), 32'(exp_timeout));
    if (e.instr_done) exp_retired++;
  endtask

  // One clock cycle: drive inputs on the falling edge, compare just after.
  task automatic step(input logic rdy, input ctl_t e, input string tag);
    @(negedge clk);
    bus.Option    = cur_opt;
    bus.Function  = cur_fn;
    bus.alu_zero  = cur_az;
    bus.rs_neg    = cur_rn;
    bus.mem_ready = rdy;
    #1;
    check_cycle(e, tag);
  endtask

  // A memory access: `waits` stalled cycles, then the completing cycle.
  task automatic mem_access(input int waits, input ctl_t e_wait, input ctl_t e_done, input string tag);
    for (int i = 0; i < waits; i++) step(1'b0, e_wait, tag);
    step(1'b1, e_done, tag);
  endtask

  task automatic run_instr(input kind_e k, input int wf, input int wm, input logic az,
                           input logic rn, input int ill_sel);
    ctl_t f_wait, f_done, dec, e, m, md;
    cur_fn = 6'($urandom);
    cur_az = az;
    cur_rn = rn;
    case (k)
      K_ADDU: begin cur_opt = 6'b000000; cur_fn = 6'b100001; end
      K_SUBU: begin cur_opt = 6'b000000; cur_fn = 6'b100011; end
      K_SRAV: begin cur_opt = 6'b000000; cur_fn = 6'b000111; end
      K_JR:   begin cur_opt = 6'b000000; cur_fn = 6'b001000; end
      K_ORI:  cur_opt = 6'b001101;
      K_LUI:  cur_opt = 6'b001111;
      K_LW:   cur_opt = 6'b100011;
      K_LH:   cur_opt = 6'b100001;
      K_SW:   cur_opt = 6'b101011;
      K_BEQ:  cur_opt = 6'b000100;
      K_BGEZ: cur_opt = 6'b000001;
      K_JAL:  cur_opt = 6'b000011;
      default: begin
        case (ill_sel)
          0: cur_opt = 6'b111111;
          1: cur_opt = 6'b000010;
          2: cur_opt = 6'b001000;
          default: begin cur_opt = 6'b000000; cur_fn = 6'b100000; end
        endcase
      end
    endcase

    f_wait = '0; f_wait.mem_read = 1'b1;
    f_done = f_wait; f_done.ir_write = 1'b1; f_done.pc_write = 1'b1;
    dec = '0; dec.alu_src_b = 2'b11; dec.alu_op = A_ADD;
    mem_access(wf, f_wait, f_done, "fetch");
    step(rbit(), dec, "decode");

    e = '0;
    case (k)
      K_ADDU, K_SUBU, K_SRAV: begin
        e.alu_src_a = 1'b1;
        e.alu_op = (k == K_ADDU) ? A_ADD : ((k == K_SUBU) ? A_SUB : A_SRAV);
        step(rbit(), e, "exec_r");
        e = '0; e.reg_write = 1'b1; e.reg_dst = 2'b01; e.instr_done = 1'b1;
        step(rbit(), e, "wb_alu");
      end
      K_ORI, K_LUI: begin
        e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; e.sign = 2'b00;
        e.alu_op = (k == K_ORI) ? A_OR : A_LUI;
        step(rbit(), e, "exec_i");
        e = '0; e.reg_write = 1'b1; e.reg_dst = 2'b00; e.instr_done = 1'b1;
        step(rbit(), e, "wb_alu");
      end
      K_LW, K_LH, K_SW: begin
        e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; e.alu_op = A_ADD; e.sign = 2'b01;
        step(rbit(), e, "addr");
        m = '0; m.iord = 1'b1;
        if (k == K_SW) begin
          m.mem_write = 1'b1;
          md = m; md.instr_done = 1'b1;
          mem_access(wm, m, md, "memwr");
        end else begin
          m.mem_read = 1'b1;
          mem_access(wm, m, m, "memrd");
          e = '0; e.reg_write = 1'b1; e.instr_done = 1'b1;
          e.mem_to_reg = (k == K_LW) ? 2'b01 : 2'b11;
          step(rbit(), e, "wb_mem");
        end
      end
      K_BEQ, K_BGEZ: begin
        e.alu_src_a = 1'b1; e.alu_op = A_SUB; e.pc_source = 2'b01; e.instr_done = 1'b1;
        e.pc_write = (k == K_BEQ) ? az : !rn;
        step(rbit(), e, "branch");
      end
      K_JAL: begin
        e.reg_write = 1'b1; e.reg_dst = 2'b10; e.mem_to_reg = 2'b10;
        e.pc_write = 1'b1; e.pc_source = 2'b10; e.instr_done = 1'b1;
        step(rbit(), e, "jal");
      end
      K_JR: begin
        e.pc_write = 1'b1; e.pc_source = 2'b11; e.instr_done = 1'b1;
        step(rbit(), e, "jr");
      end
      default: exp_illegal = 1'b1;
    endcase
    $display("instr %s opt=%b fn=%b fetch_wait=%0d mem_wait=%0d retired=%0d",
             k.name(), cur_opt, cur_fn, wf, wm, exp_retired);
  endtask

  initial begin
    ctl_t f_wait;
    kind_e k;
    bus.Option = '0; bus.Function = '0; bus.alu_zero = 1'b0; bus.rs_neg = 1'b0;
    bus.mem_ready = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check_cycle('0, "reset");
    @(negedge clk);
    reset_n = 1'b1;
    bus.mem_ready = rbit();
    #1;
    check_cycle('0, "idle");

    // Directed cases from the plan, plus the longest non-timing-out fetch stall
    run_instr(K_ADDU, 0, 0, 1'b0, 1'b0, 0);
    run_instr(K_LW,   0, 3, 1'b0, 1'b0, 0);
    run_instr(K_BEQ,  0, 0, 1'b1, 1'b0, 0);
    run_instr(K_BEQ,  0, 0, 1'b0, 1'b0, 0);
    run_instr(K_BGEZ, 0, 0, 1'b0, 1'b1, 0);
    run_instr(K_JAL,  0, 0, 1'b0, 1'b0, 0);
    run_instr(K_ILL,  0, 0, 1'b0, 1'b0, 0);
    run_instr(K_ORI,  TIMEOUT - 1, 0, 1'b0, 1'b0, 0);
    run_instr(K_SW,   1, TIMEOUT - 1, 1'b0, 1'b0, 0);

    // Random instruction stream with random wait states
    for (int n = 0; n < 80; n++) begin
      k = kind_e'($urandom_range(0, 12));
      run_instr(k, $urandom_range(0, 3), $urandom_range(0, 3), rbit(), rbit(),
                $urandom_range(0, 3));
    end

    // Memory never answers in FETCH: timeout after TIMEOUT stalled cycles, then ERR
    f_wait = '0; f_wait.mem_read = 1'b1;
    for (int i = 0; i < TIMEOUT; i++) step(1'b0, f_wait, "fetch_stall");
    exp_timeout = 1'b1;
    for (int i = 0; i < 4; i++) step(rbit(), '0, "err");

    // Reset while in ERR clears the flags and the counter
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    exp_retired = 0; exp_illegal = 1'b0; exp_timeout = 1'b0;
    check_cycle('0, "reset_err");

    // Reset asserted mid-fetch drops MemRead without waiting for a clock edge
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check_cycle('0, "idle2");
    step(1'b0, f_wait, "fetch_wait");
    step(1'b0, f_wait, "fetch_wait");
    #2;
    reset_n = 1'b0;
    #1;
    check("reset_drop.MemRead", 32'(bus.MemRead), 32'd0);
    check_cycle('0, "reset_mid");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Multi-cycle successor to the single-cycle MIPS decode controller: a Moore FSM that sequences fetch, decode, execute, memory and write-back over several cycles.
- Sits between the IR (Option/Function) and a shared-ALU, single-memory datapath.
- Adds a variable-latency memory handshake with timeout, in-controller branch resolution, and instruction retire/illegal reporting.

Parameters:
- ALUOP_W, 3, ALUOp width; same ALUOp encoding as the current single-cycle decode.
- TIMEOUT, 16, max cycles waiting for mem_ready before the error state; 0 disables the timeout.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous, active-low reset.
- Option  in  6  IR[31:26].
- Function  in  6  IR[5:0].
- alu_zero  in  1  ALU result==0; valid in BRANCH.
- rs_neg  in  1  GPR[rs][31]; valid in BRANCH.
- mem_ready  in  1  memory completes the current access this cycle.
- MemRead, MemWrite  out  1  memory request; held until mem_ready.
- IorD  out  1  0=PC address, 1=ALUOut address.
- IRWrite  out  1  latch IR.
- PCWrite  out  1  update PC.
- PCSource  out  2  00 PC+4, 01 branch target, 10 jump target, 11 GPR[rs].
- ALUSrcA  out  1  0=PC, 1=rs.
- ALUSrcB  out  2  00 rt, 01 const 4, 10 ext imm, 11 ext imm<<2.
- ALUOp  out  ALUOP_W  ALU function.
- Sign  out  2  extender mode; encoding unchanged from single-cycle.
- RegDst  out  2  00 rt, 01 rd, 10 $31.
- MemtoReg  out  2  00 ALUOut, 01 MDR word, 10 PC (jal), 11 MDR half.
- RegWrite  out  1  GPR write.
- instr_done  out  1  one-cycle pulse on retire.
- illegal  out  1  sticky; set on undecoded opcode.
- timeout_err  out  1  sticky; set on memory timeout.
- retired  out  CNT_W  retired-instruction count.

Behaviour:
- States (4-bit): IDLE, FETCH, DECODE, EXEC_R, EXEC_I, ADDR, MEMRD, MEMWR, WB_ALU, WB_MEM, BRANCH, JAL, JR, ERR.
- Reset (reset_n=0, async): state=IDLE; all outputs 0, including counters and sticky flags.
- IDLE -> FETCH unconditionally next cycle.
- FETCH: MemRead=1, IorD=0.
  - Stays in FETCH while mem_ready=0.
  - On mem_ready: IRWrite=1, PCWrite=1, PCSource=00 (same cycle); next state DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=add (branch target into ALUOut). Next state by Option/Function:
  - addu/subu/srav -> EXEC_R.
  - ori/lui -> EXEC_I.
  - lw/lh/sw -> ADDR.
  - beq/bgez -> BRANCH.
  - jal -> JAL.
  - jr -> JR.
  - Any other opcode -> illegal set, instr_done=0, next state FETCH.
- EXEC_R: ALUSrcA=1, ALUSrcB=00, ALUOp per Function. Next state WB_ALU with RegDst=01.
- EXEC_I: ALUSrcA=1, ALUSrcB=10, ALUOp ori/lui, Sign zero-extend. Next state WB_ALU with RegDst=00.
- ADDR: ALUSrcA=1, ALUSrcB=10, add, Sign signed. Next state MEMRD (lw/lh) or MEMWR (sw).
- MEMRD: MemRead=1, IorD=1; waits for mem_ready, then WB_MEM.
- MEMWR: MemWrite=1, IorD=1; waits for mem_ready, then retire -> FETCH.
- WB_ALU / WB_MEM: RegWrite=1; MemtoReg=00 / 01 (lw) / 11 (lh); then retire -> FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, subtract.
  - PCWrite = (beq & alu_zero) | (bgez & ~rs_neg); PCSource=01.
  - Retire -> FETCH.
- JAL: RegWrite=1, RegDst=10, MemtoReg=10, PCWrite=1, PCSource=10; retire -> FETCH.
  - GPR write uses the already-incremented PC.
- JR: PCWrite=1, PCSource=11; retire -> FETCH.
- Retire: instr_done=1 in the final state; retired increments by 1 the same edge, wrapping at 2^CNT_W.
- Wait-cycle counter:
  - Counts cycles spent with MemRead|MemWrite=1 and mem_ready=0.
  - Cleared on mem_ready and on state entry.
  - If TIMEOUT>0 and the count reaches TIMEOUT: timeout_err=1, state=ERR.
- ERR: all outputs 0 except the sticky flags and retired; exits only by reset.
- mem_ready=1 in the first request cycle means zero wait states.
- Requests stay asserted and stable while waiting; a mem_ready outside FETCH/MEMRD/MEMWR is ignored.
- Latency at zero wait states, in cycles:
  - R-type, ori, lui, sw: 4.
  - lw, lh: 5.
  - beq, bgez, jal, jr: 3.
- Reset mid-access drops MemRead/MemWrite asynchronously.

Decomposition:
- Shared package mips_pkg holds:
  - Opcode/Function constants: ADDU 100001, SUBU 100011, SRAV 000111, JR 001000, ORI 001101, LW 100011, LH 100001, SW 101011, BEQ 000100, BGEZ 000001, LUI 001111, JAL 000011.
  - ALUOp, PCSource, ALUSrcB, RegDst and MemtoReg encodings.
  - State enum.
- One sub-module, mc_decode: combinational decode of Option/Function into the instruction class and ALUOp.

Test Plan:
- Reset then addu with mem_ready tied 1 -> FETCH, DECODE, EXEC_R, WB_ALU; RegWrite=1 and RegDst=01 in cycle 4; instr_done pulse; retired=1.
- lw with mem_ready delayed 3 cycles in MEMRD -> MemRead and IorD=1 held 4 cycles; WB_MEM with MemtoReg=01; total 8 cycles.
- beq with alu_zero=1, then alu_zero=0 -> PCWrite=1/PCSource=01 only in the first case; both retire in 3 cycles.
- bgez with rs_neg=1 -> no PCWrite; jal -> RegDst=10, MemtoReg=10, PCSource=10 in a single cycle.
- Option=6'b111111 -> illegal=1, no instr_done, returns to FETCH; retired unchanged.
- mem_ready held 0 in FETCH with TIMEOUT=16 -> timeout_err=1 after 16 waits, ERR, outputs 0; reset_n low mid-ERR -> IDLE, flags cleared.
